// File: rtl/axis_pkt_framer_pkg.sv
// Shared types and helpers for the AXI-Stream packet framer.
// Holds the FSM state encoding, the packet-length clamp and the counter width derivation.
package axis_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counters must be able to hold MAX_PKT_LENGTH itself, not just MAX_PKT_LENGTH-1.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len) + 1;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/axis_pkt_framer_if.sv
// AXI-Stream bundle with first/last-beat sideband, shared by the framer's input and output.
interface axis_pkt_framer_if #(
    parameter int unsigned TDATA_WIDTH = 16
) ();

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic                   tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );

endinterface

// File: rtl/axis_pkt_framer_skid_buf.sv
// Two-entry register slice: full throughput, registered ready, no combinational ready path.
module axis_skid_buf #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_acc;

    assign in_ready  = ~skid_valid_q;
    assign in_acc    = in_valid & ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign empty     = ~main_valid_q & ~skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q || out_ready) begin
            // Output slot is free this cycle: refill from skid first to keep ordering.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_acc;
                if (in_acc) begin
                    main_data_d = in_data;
                end
            end
        end else if (in_acc) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/axis_pkt_framer.sv
// Frames a sample stream into fixed-length packets with tuser/tlast, in armed bursts or
// continuously, with abort at a packet boundary and a registered backpressure-safe output.
module axis_pkt_framer
    import axis_pkt_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH    = 16,
    parameter int unsigned MAX_PKT_LENGTH = 512,
    parameter int unsigned NUM_PKTS_WIDTH = 16,
    localparam int unsigned LEN_W         = len_width(MAX_PKT_LENGTH)
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic [LEN_W-1:0]          pkt_length,
    input  logic [NUM_PKTS_WIDTH-1:0] num_pkts,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PKTS_WIDTH-1:0] pkt_cnt,
    axis_pkt_framer_if.slave          s_axis,
    axis_pkt_framer_if.master         m_axis
);

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]          eff_len_q, eff_len_d;
    logic [LEN_W-1:0]          cur_len;
    logic [NUM_PKTS_WIDTH-1:0] num_pkts_q, num_pkts_d;
    logic [NUM_PKTS_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                      abort_pend_q, abort_pend_d;
    logic                      done_q, done_d;

    logic                     in_run, acc, tag_user, tag_last, last_pkt;
    logic                     buf_in_ready, buf_out_valid, buf_empty;
    logic [TDATA_WIDTH+1:0]   buf_in_data, buf_out_data;

    assign in_run = (state_q == RUN);
    assign acc    = in_run & s_axis.tvalid & buf_in_ready;

    // Outside RUN the converter is never stalled; its samples are simply dropped.
    assign s_axis.tready = in_run ? buf_in_ready : 1'b1;

    // The first beat of a packet uses the live length; later beats use the latched copy.
    assign cur_len  = (beat_cnt_q == '0) ?
                      LEN_W'(clamp_len(32'(pkt_length), MAX_PKT_LENGTH)) : eff_len_q;
    assign tag_user = (beat_cnt_q == '0);
    assign tag_last = (beat_cnt_q == cur_len - LEN_W'(1));
    assign last_pkt = (num_pkts_q != '0) &&
                      (pkt_cnt_q + NUM_PKTS_WIDTH'(1) == num_pkts_q);

    assign buf_in_data = {s_axis.tdata, tag_last, tag_user};

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        eff_len_d    = eff_len_q;
        num_pkts_d   = num_pkts_q;
        pkt_cnt_d    = pkt_cnt_q;
        abort_pend_d = abort_pend_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_pkts_d   = num_pkts;
                    pkt_cnt_d    = '0;
                    beat_cnt_d   = '0;
                    abort_pend_d = 1'b0;
                    state_d      = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    abort_pend_d = 1'b1;
                end
                if (acc) begin
                    if (tag_user) begin
                        eff_len_d = cur_len;
                    end
                    if (tag_last) begin
                        beat_cnt_d = '0;
                        if (pkt_cnt_q != '1) begin
                            pkt_cnt_d = pkt_cnt_q + NUM_PKTS_WIDTH'(1);
                        end
                        if (last_pkt || abort_pend_q || abort) begin
                            abort_pend_d = 1'b0;
                            state_d      = FLUSH;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (buf_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            eff_len_q    <= LEN_W'(1);
            num_pkts_q   <= '0;
            pkt_cnt_q    <= '0;
            abort_pend_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            eff_len_q    <= eff_len_d;
            num_pkts_q   <= num_pkts_d;
            pkt_cnt_q    <= pkt_cnt_d;
            abort_pend_q <= abort_pend_d;
            done_q       <= done_d;
        end
    end

    axis_skid_buf #(
        .WIDTH (TDATA_WIDTH + 2)
    ) u_skid_buf (
        .aclk      (aclk),
        .reset     (reset),
        .in_valid  (in_run & s_axis.tvalid),
        .in_ready  (buf_in_ready),
        .in_data   (buf_in_data),
        .out_valid (buf_out_valid),
        .out_ready (m_axis.tready),
        .out_data  (buf_out_data),
        .empty     (buf_empty)
    );

    assign m_axis.tvalid = buf_out_valid;
    assign m_axis.tdata  = buf_out_data[TDATA_WIDTH+1:2];
    assign m_axis.tlast  = buf_out_data[1];
    assign m_axis.tuser  = buf_out_data[0];

    // busy drops on the same edge that raises done.
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench for axis_pkt_framer: directed bursts push expected beats, a monitor pops them.
module tb_axis_pkt_framer;

    localparam int unsigned DW   = 16;
    localparam int unsigned MAXL = 512;
    localparam int unsigned NPW  = 16;
    localparam int unsigned LW   = 10;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    logic           aclk = 1'b0;
    logic           reset = 1'b1;
    logic [LW-1:0]  pkt_length;
    logic [NPW-1:0] num_pkts;
    logic           start;
    logic           abort;
    logic           busy;
    logic           done;
    logic [NPW-1:0] pkt_cnt;

    axis_pkt_framer_if #(.TDATA_WIDTH(DW)) s_if ();
    axis_pkt_framer_if #(.TDATA_WIDTH(DW)) m_if ();

    axis_pkt_framer #(
        .TDATA_WIDTH    (DW),
        .MAX_PKT_LENGTH (MAXL),
        .NUM_PKTS_WIDTH (NPW)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .pkt_length (pkt_length),
        .num_pkts   (num_pkts),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .pkt_cnt    (pkt_cnt),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    always #5 aclk = ~aclk;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    last_pop_cyc = 0;
    bit    rand_rdy = 1'b0;
    bit    rand_gap = 1'b0;
    logic  rdy_fix = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
    initial begin : monitor
        logic              prev_stall = 1'b0;
        logic              prev_rst = 1'b1;
        logic [DW+2:0]     prev_bus = '0;
        beat_t             e;
        forever begin
            @(negedge aclk);
            if (prev_stall && !prev_rst) begin
                chk("hold_stable", {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser}, prev_bus);
            end
            if (!reset && m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got tdata %0d, want no beat (t=%0t)",
                             m_if.tdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_if.tdata, e.d);
                    chk("tlast", m_if.tlast, e.l);
                    chk("tuser", m_if.tuser, e.u);
                    last_pop_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_bus   = {m_if.tvalid, m_if.tdata, m_if.tlast, m_if.tuser};
            prev_rst   = reset;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic begin_burst(input int len, input int n);
        pkt_length = LW'(len);
        num_pkts   = NPW'(n);
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one beat, hold until accepted; push the hand-computed expectation if it should appear.
    task automatic send(input int d, input bit l, input bit u, input bit ex, input bit ab);
        bit got;
        int n;
        if (rand_gap) begin
            repeat ($urandom_range(0, 1)) tick();
        end
        s_if.tvalid = 1'b1;
        s_if.tdata  = DW'(d);
        abort       = ab;
        got = 1'b0;
        n = 0;
        while (!got && n < 200) begin
            @(negedge aclk);
            got = s_if.tready;
            tick();
            abort = 1'b0;
            n++;
        end
        s_if.tvalid = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %0d not accepted, want accept in 200 cycles", d);
        end else if (ex) begin
            exp_q.push_back('{d: DW'(d), l: l, u: u});
        end
    endtask

    task automatic wait_done(input int prev, input string name);
        int n = 0;
        while (done_cnt == prev && n < 3000) begin
            tick();
            n++;
        end
        chk(name, done_cnt, prev + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        pkt_length  = LW'(4);
        num_pkts    = '0;
        reset       = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge aclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_s_tready", s_if.tready, 1);
        tick();

        // 1: three packets of four beats
        d0 = done_cnt;
        begin_burst(4, 3);
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) send(p * 4 + b, b == 3, b == 0, 1'b1, 1'b0);
        wait_done(d0, "t1_done");
        chk("t1_pkt_cnt", pkt_cnt, 3);
        chk("t1_done_lat", done_cyc - last_pop_cyc, 2);
        chk("t1_drained", exp_q.size(), 0);

        // 2: zero length clamps to 1; oversize clamps to MAX
        d0 = done_cnt;
        begin_burst(0, 2);
        send(100, 1'b1, 1'b1, 1'b1, 1'b0);
        send(101, 1'b1, 1'b1, 1'b1, 1'b0);
        wait_done(d0, "t2a_done");
        chk("t2a_pkt_cnt", pkt_cnt, 2);
        d0 = done_cnt;
        begin_burst(600, 1);
        for (int b = 0; b < 512; b++) send(1000 + b, b == 511, b == 0, 1'b1, 1'b0);
        wait_done(d0, "t2b_done");
        chk("t2b_pkt_cnt", pkt_cnt, 1);

        // 3: continuous mode under random backpressure, abort in the sixth packet
        rand_rdy = 1'b1;
        rand_gap = 1'b1;
        d0 = done_cnt;
        begin_burst(8, 0);
        for (int p = 0; p < 6; p++)
            for (int b = 0; b < 8; b++)
                send(2000 + p * 8 + b, b == 7, b == 0, 1'b1, (p == 5) && (b == 3));
        wait_done(d0, "t3_done");
        chk("t3_pkt_cnt", pkt_cnt, 6);
        for (int b = 0; b < 4; b++) send(3000 + b, 1'b0, 1'b0, 1'b0, 1'b0);
        rand_rdy = 1'b0;
        rand_gap = 1'b0;
        repeat (6) tick();
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_idle", busy, 0);

        // 4: length change mid-packet applies from the next packet
        d0 = done_cnt;
        begin_burst(4, 2);
        for (int b = 0; b < 4; b++) begin
            if (b == 2) pkt_length = LW'(6);
            send(4000 + b, b == 3, b == 0, 1'b1, 1'b0);
        end
        for (int b = 0; b < 6; b++) send(4100 + b, b == 5, b == 0, 1'b1, 1'b0);
        wait_done(d0, "t4_done");
        chk("t4_pkt_cnt", pkt_cnt, 2);

        // 5: reset with a full buffer and a stalled output
        begin_burst(1, 0);
        rdy_fix = 1'b0;
        repeat (2) tick();
        send(5000, 1'b1, 1'b1, 1'b0, 1'b0);
        send(5001, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        chk("t5_full_tready", s_if.tready, 0);
        chk("t5_pre_pkt_cnt", pkt_cnt, 2);
        tick();
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge aclk);
        chk("t5_tvalid", m_if.tvalid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        chk("t5_done", done, 0);
        tick();
        rdy_fix = 1'b1;
        repeat (4) tick();
        chk("t5_no_done", done_cnt, d0);
        begin_burst(3, 1);
        for (int b = 0; b < 3; b++) send(5100 + b, b == 2, b == 0, 1'b1, 1'b0);
        wait_done(d0, "t5_restart_done");

        // 6: abort in IDLE and start while busy have no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        d0 = done_cnt;
        begin_burst(2, 2);
        send(6000, 1'b0, 1'b1, 1'b1, 1'b0);
        num_pkts = NPW'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        send(6001, 1'b1, 1'b0, 1'b1, 1'b0);
        send(6002, 1'b0, 1'b1, 1'b1, 1'b0);
        send(6003, 1'b1, 1'b0, 1'b1, 1'b0);
        wait_done(d0, "t6a_done");
        repeat (10) tick();
        chk("t6a_single_done", done_cnt, d0 + 1);
        chk("t6a_pkt_cnt", pkt_cnt, 2);

        // abort on the final tlast gives one exit, and does not leak into the next burst
        d0 = done_cnt;
        begin_burst(2, 1);
        send(6100, 1'b0, 1'b1, 1'b1, 1'b0);
        send(6101, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(d0, "t6b_done");
        repeat (10) tick();
        chk("t6b_single_done", done_cnt, d0 + 1);
        d0 = done_cnt;
        begin_burst(2, 2);
        for (int b = 0; b < 4; b++) send(6200 + b, b[0], !b[0], 1'b1, 1'b0);
        wait_done(d0, "t6c_done");
        chk("t6c_pkt_cnt", pkt_cnt, 2);

        repeat (4) tick();
        chk("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
